imem_unlock_ctrl: RTL and testbench

Sequencer that sits in front of the key-locked instruction memory and owns both its 8-bit key input and its address input. It shifts in a key serially, proves it by fetching a known signature word, and only then hands the memory address port to the CPU PC and enables the core. Wrong keys are cleared and counted; after MAX_TRIES failures the block locks out until reset.

---
 rtl/imem_unlock_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_imem_unlock_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_unlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_unlock_ctrl
// Purpose  : Key sequencer in front of a key-locked instruction memory. A key
//            is shifted in serially (MSB first) and then proven by fetching a
//            known signature word from SIG_ADDR. Only after a successful proof
//            does the memory address port follow the CPU PC and the core get
//            its run enable. Wrong keys are cleared and counted; after
//            MAX_TRIES failures the block stays locked out until reset.
// Ports    : clk          - system clock, all state on the rising edge
//            rst          - asynchronous, active-low reset
//            key_start    - pulse: begin (or restart) a key load
//            key_bit      - serial key bit, MSB first
//            key_bit_vld  - key_bit valid this cycle
//            pc_i         - CPU fetch address
//            imem_rd_i    - instruction memory read data (combinational)
//            imem_addr_o  - instruction memory address
//            imem_key_o   - instruction memory key
//            cpu_en_o     - core run enable
//            busy_o       - key load or proof in progress
//            locked_out_o - lockout reached
//            fail_cnt_o   - failed proofs so far, saturating at MAX_TRIES
// Revision : 1.0 - initial release
// ============================================================================
module imem_unlock_ctrl #(
  parameter logic [31:0] SIG_ADDR  = 32'h0000_0000,
  parameter logic [31:0] SIG_WORD  = 32'h0062_E233,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic        key_bit,
  input  logic        key_bit_vld,
  input  logic [31:0] pc_i,
  input  logic [31:0] imem_rd_i,
  output logic [31:0] imem_addr_o,
  output logic [7:0]  imem_key_o,
  output logic        cpu_en_o,
  output logic        busy_o,
  output logic        locked_out_o,
  output logic [2:0]  fail_cnt_o
);

  localparam logic [2:0] C_MAX_TRIES = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_PROBE   = 3'd2,
    S_CHECK   = 3'd3,
    S_RUN     = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] capture_q, capture_d;
  logic [2:0]  fail_cnt_q, fail_cnt_d;
  logic [2:0]  fail_inc;

  assign fail_inc = fail_cnt_q + 3'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      capture_q  <= 32'h0;
      fail_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      capture_q  <= capture_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    capture_d  = capture_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (key_start) begin
          state_d   = S_SHIFT;
          shift_d   = 8'h00;
          bit_cnt_d = 3'd0;
        end
      end

      S_SHIFT: begin
        // A restart takes priority over a bit arriving in the same cycle.
        if (key_start) begin
          shift_d   = 8'h00;
          bit_cnt_d = 3'd0;
        end else if (key_bit_vld) begin
          shift_d   = {shift_q[6:0], key_bit};
          // Counter wraps to 0 on the eighth bit, ready for any later load.
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PROBE;
          end
        end
      end

      S_PROBE: begin
        capture_d = imem_rd_i;
        state_d   = S_CHECK;
      end

      S_CHECK: begin
        if (capture_q == SIG_WORD) begin
          state_d = S_RUN;
        end else begin
          shift_d = 8'h00;
          if (fail_cnt_q != C_MAX_TRIES) begin
            fail_cnt_d = fail_inc;
          end
          if (fail_inc >= C_MAX_TRIES) begin
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_RUN: begin
        // Proven key is frozen; only reset can leave this state.
      end

      S_LOCKOUT: begin
        shift_d = 8'h00;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    imem_addr_o  = SIG_ADDR;
    imem_key_o   = 8'h00;
    cpu_en_o     = 1'b0;
    busy_o       = 1'b0;
    locked_out_o = 1'b0;

    case (state_q)
      S_SHIFT: begin
        busy_o = 1'b1;
      end
      S_PROBE, S_CHECK: begin
        busy_o     = 1'b1;
        imem_key_o = shift_q;
      end
      S_RUN: begin
        imem_addr_o = pc_i;
        imem_key_o  = shift_q;
        cpu_en_o    = 1'b1;
      end
      S_LOCKOUT: begin
        locked_out_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign fail_cnt_o = fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_unlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_unlock_ctrl
// Purpose  : Directed self-checking bench for imem_unlock_ctrl. A small
//            key-locked memory model returns the signature word only for key
//            8'h5A at address 0, and zero for any other key.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_unlock_ctrl;

  logic        clk;
  logic        rst;
  logic        key_start;
  logic        key_bit;
  logic        key_bit_vld;
  logic [31:0] pc;
  logic [31:0] imem_rd;
  logic [31:0] imem_addr;
  logic [7:0]  imem_key;
  logic        cpu_en;
  logic        busy;
  logic        locked_out;
  logic [2:0]  fail_cnt;

  int checks   = 0;
  int failures = 0;

  imem_unlock_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_start    (key_start),
    .key_bit      (key_bit),
    .key_bit_vld  (key_bit_vld),
    .pc_i         (pc),
    .imem_rd_i    (imem_rd),
    .imem_addr_o  (imem_addr),
    .imem_key_o   (imem_key),
    .cpu_en_o     (cpu_en),
    .busy_o       (busy),
    .locked_out_o (locked_out),
    .fail_cnt_o   (fail_cnt)
  );

  // Locked memory: only the right key unlocks it; locked reads return zero.
  assign imem_rd = (imem_key == 8'h5A)
                 ? ((imem_addr == 32'h0) ? 32'h0062_E233 : {imem_addr[15:0], 16'h1234})
                 : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; asserts reset with no clock edge before checking.
  task automatic reset_now();
    rst         = 1'b0;
    key_start   = 1'b0;
    key_bit_vld = 1'b0;
    #1;
    chk("rst_cpu_en", 32'(cpu_en), 32'h0);
    chk("rst_key",    32'(imem_key), 32'h0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_busy",   32'(busy), 32'h0);
    chk("rst_locked", 32'(locked_out), 32'h0);
    chk("rst_fail",   32'(fail_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after E0 (state SHIFT).
  task automatic start_key();
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    chk("start_busy", 32'(busy), 32'h1);
  endtask

  // Returns at the negedge after the edge accepting the 8th bit (PROBE).
  task automatic shift_bits(input logic [7:0] k, input int gap);
    for (int i = 7; i >= 0; i--) begin
      key_bit     = k[i];
      key_bit_vld = 1'b1;
      @(negedge clk);
      key_bit_vld = 1'b0;
      if (i > 0) begin
        chk("shift_key0", 32'(imem_key), 32'h0);
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  task automatic wrong_key(input logic [2:0] exp_fail, input logic exp_lock);
    start_key();
    shift_bits(8'hA5, 0);
    chk("wrong_probe_key", 32'(imem_key), 32'hA5);
    repeat (2) @(negedge clk);
    chk("wrong_cpu_en", 32'(cpu_en), 32'h0);
    chk("wrong_key_clr", 32'(imem_key), 32'h0);
    chk("wrong_fail", 32'(fail_cnt), 32'(exp_fail));
    chk("wrong_lock", 32'(locked_out), 32'(exp_lock));
    chk("wrong_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst         = 1'b0;
    key_start   = 1'b0;
    key_bit     = 1'b0;
    key_bit_vld = 1'b0;
    pc          = 32'h0;
    @(negedge clk);
    reset_now();

    // Correct key
    start_key();
    shift_bits(8'h5A, 0);
    chk("probe_key",  32'(imem_key), 32'h5A);
    chk("probe_addr", imem_addr, 32'h0);
    chk("probe_busy", 32'(busy), 32'h1);
    chk("probe_cpu",  32'(cpu_en), 32'h0);
    @(negedge clk);
    chk("check_cpu",  32'(cpu_en), 32'h0);
    chk("check_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("run_cpu",  32'(cpu_en), 32'h1);
    chk("run_key",  32'(imem_key), 32'h5A);
    chk("run_busy", 32'(busy), 32'h0);
    chk("run_fail", 32'(fail_cnt), 32'h0);
    pc = 32'h4; #1;
    chk("run_pc4", imem_addr, 32'h4);
    pc = 32'h8; #1;
    chk("run_pc8", imem_addr, 32'h8);

    // Async reset out of RUN, then one wrong key
    reset_now();
    wrong_key(3'd1, 1'b0);

    // Lockout after three wrong keys
    reset_now();
    wrong_key(3'd1, 1'b0);
    wrong_key(3'd2, 1'b0);
    wrong_key(3'd3, 1'b1);
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    shift_bits(8'h5A, 0);
    repeat (2) @(negedge clk);
    chk("lock_cpu",  32'(cpu_en), 32'h0);
    chk("lock_key",  32'(imem_key), 32'h0);
    chk("lock_busy", 32'(busy), 32'h0);
    chk("lock_flag", 32'(locked_out), 32'h1);
    chk("lock_fail", 32'(fail_cnt), 32'h3);
    reset_now();
    start_key();
    shift_bits(8'h5A, 0);
    repeat (2) @(negedge clk);
    chk("relock_run_cpu", 32'(cpu_en), 32'h1);

    // Restart collision: start wins over a same-cycle bit
    reset_now();
    wrong_key(3'd1, 1'b0);
    start_key();
    for (int j = 0; j < 5; j++) begin
      key_bit     = 1'b1;
      key_bit_vld = 1'b1;
      @(negedge clk);
    end
    key_start   = 1'b1;
    key_bit     = 1'b1;
    key_bit_vld = 1'b1;
    @(negedge clk);
    key_start   = 1'b0;
    key_bit_vld = 1'b0;
    shift_bits(8'h5A, 0);
    chk("coll_probe_key", 32'(imem_key), 32'h5A);
    repeat (2) @(negedge clk);
    chk("coll_cpu",  32'(cpu_en), 32'h1);
    chk("coll_key",  32'(imem_key), 32'h5A);
    chk("coll_fail", 32'(fail_cnt), 32'h1);

    // Gapped bits, then key_start ignored in RUN
    reset_now();
    start_key();
    shift_bits(8'h5A, 3);
    chk("gap_probe_key", 32'(imem_key), 32'h5A);
    @(negedge clk);
    chk("gap_check_cpu", 32'(cpu_en), 32'h0);
    @(negedge clk);
    chk("gap_run_cpu", 32'(cpu_en), 32'h1);
    key_start   = 1'b1;
    key_bit     = 1'b1;
    key_bit_vld = 1'b1;
    repeat (3) @(negedge clk);
    key_start   = 1'b0;
    key_bit_vld = 1'b0;
    chk("run_ign_key",  32'(imem_key), 32'h5A);
    chk("run_ign_cpu",  32'(cpu_en), 32'h1);
    chk("run_ign_busy", 32'(busy), 32'h0);

    // Async reset mid-PROBE
    reset_now();
    start_key();
    shift_bits(8'h5A, 0);
    chk("midprobe_busy", 32'(busy), 32'h1);
    reset_now();
    @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 32'h0);
    chk("post_rst_idle_key",  32'(imem_key), 32'h0);
    start_key();
    shift_bits(8'h5A, 0);
    repeat (2) @(negedge clk);
    chk("final_run_cpu", 32'(cpu_en), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
